// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column per slot, 2-flop row sync,
// whole-map debounce across full scans, single-key press events with a strobe.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi_key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [3:0]    row_m, row_s;
  logic [15:0]   snap, prev, deb, deb_old, scan_word;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          slot_end, scan_end, eval;
  logic [4:0]    ones;
  logic [3:0]    idx;
  logic          fire;

  assign slot_end  = (div == DW'(SCAN_DIV - 1));
  assign scan_end  = slot_end && (col == 2'd3);
  // Column 3 completes the word straight from the synchronizer.
  assign scan_word = {~row_s, snap[11:0]};
  assign col_out   = ~(4'b0001 << col);

  always_comb begin
    cnt_nxt = CW'(1);
    if (scan_word == prev)
      cnt_nxt = (cnt == CW'(DEBOUNCE_SCANS)) ? cnt : cnt + CW'(1);
  end

  always_comb begin
    ones = 5'd0;
    idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (deb[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
  end

  // deb_old holds the map before the latest end-of-scan, so eval sees the change.
  assign fire = eval && (deb != deb_old) && (ones == 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      col       <= '0;
      row_m     <= '0;
      row_s     <= '0;
      snap      <= '0;
      prev      <= '0;
      cnt       <= '0;
      deb       <= '0;
      deb_old   <= '0;
      eval      <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
      div   <= slot_end ? '0 : div + DW'(1);
      if (slot_end) begin
        col                  <= col + 2'd1;
        snap[{col, 2'b00} +: 4] <= ~row_s;
      end
      eval <= scan_end;
      if (scan_end) begin
        prev    <= scan_word;
        cnt     <= cnt_nxt;
        deb_old <= deb;
        if (cnt_nxt >= CW'(DEBOUNCE_SCANS))
          deb <= scan_word;
      end
      key_valid <= fire;
      if (fire)
        key_code <= idx;
      if (eval) begin
        key_down  <= |deb;
        multi_key <= (ones >= 5'd2);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: ideal keypad matrix model, directed plan steps and
// a random phase checked against an event-level press/report model.
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in, col_out, key_code;
  logic       key_valid, key_down, multi_key;

  logic [15:0] keys = '0;
  logic [15:0] mdeb = '0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sq_code[$];
  int sq_cyc[$];
  int exp_q[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .multi_key(multi_key)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A row reads low when a pressed key sits on a column currently driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
  end

  always @(negedge clk)
    if (key_valid) begin
      sq_code.push_back(int'(key_code));
      sq_cyc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bit_idx(input logic [15:0] s);
    int r = 0;
    for (int i = 0; i < 16; i++) if (s[i]) r = i;
    return r;
  endfunction

  // Model: a held set that lasts long enough becomes the debounced map;
  // a change into exactly one key is reported.
  task automatic apply(input logic [15:0] s);
    keys = s;
    if (s != mdeb) begin
      if ($countones(s) == 1) exp_q.push_back(bit_idx(s));
      mdeb = s;
    end
  endtask

  task automatic check_strobes(input string tag);
    chk({tag, "_count"}, 32'(sq_code.size()), 32'(exp_q.size()));
    for (int i = 0; i < sq_code.size() && i < exp_q.size(); i++)
      chk({tag, "_code"}, 32'(sq_code[i]), 32'(exp_q[i]));
    sq_code.delete();
    sq_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [3:0]  ecol;
    logic [15:0] s;
    logic        kd_seen;
    logic        found;
    int          p;

    // 1. reset and column scan
    tick(2);
    chk("rst_col", 32'(col_out), 32'(4'hE));
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_down", 32'(key_down), 32'd0);
    chk("rst_multi", 32'(multi_key), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      ecol = ~(4'b0001 << ((n / 4) % 4));
      chk("scan_col", 32'(col_out), 32'(ecol));
    end
    check_strobes("idle");

    // 2. clean press of key 6, then release
    apply(16'(1) << 6);
    p = cyc;
    tick(10 * SCAN);
    chk("press_lat", 32'(sq_cyc.size() > 0 && sq_cyc[0] - p <= 4 * SCAN + 3), 32'd1);
    chk("press_down", 32'(key_down), 32'd1);
    chk("press_multi", 32'(multi_key), 32'd0);
    check_strobes("press");
    apply('0);
    tick(4 * SCAN);
    chk("release_down", 32'(key_down), 32'd0);
    check_strobes("release");

    // 3. bounce shorter than the debounce window
    kd_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? (16'(1) << 6) : 16'h0;
      for (int j = 0; j < 20; j++) begin
        tick(1);
        kd_seen |= key_down;
      end
    end
    keys = '0;
    for (int j = 0; j < 4 * SCAN; j++) begin
      tick(1);
      kd_seen |= key_down;
    end
    chk("bounce_down", 32'(kd_seen), 32'd0);
    check_strobes("bounce");

    // 4. two keys, then release one
    apply(16'h8001);
    tick(6 * SCAN);
    chk("two_multi", 32'(multi_key), 32'd1);
    chk("two_down", 32'(key_down), 32'd1);
    check_strobes("two");
    apply(16'h0001);
    tick(6 * SCAN);
    chk("one_multi", 32'(multi_key), 32'd0);
    chk("one_down", 32'(key_down), 32'd1);
    check_strobes("two_rel");
    apply('0);
    tick(6 * SCAN);
    check_strobes("two_off");

    // 5. rollover 5 -> 10
    apply(16'(1) << 5);
    tick(6 * SCAN);
    apply(16'(1) << 10);
    tick(6 * SCAN);
    check_strobes("roll");

    // 6. reset at divider 2 of column 2 with key 9 held
    apply(16'(1) << 9);
    tick(6 * SCAN);
    check_strobes("k9");
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN && !found; i++) begin
      ecol = col_out;
      tick(1);
      if (col_out == 4'hB && ecol != 4'hB) found = 1'b1;
    end
    chk("col2_seen", 32'(found), 32'd1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    p = cyc;
    chk("mid_rst_col", 32'(col_out), 32'(4'hE));
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_down", 32'(key_down), 32'd0);
    chk("mid_rst_multi", 32'(multi_key), 32'd0);
    chk("mid_rst_code", 32'(key_code), 32'd0);
    mdeb = '0;
    apply(16'(1) << 9);
    tick(5 * SCAN);
    chk("mid_rst_lat", 32'(sq_cyc.size() > 0 && sq_cyc[0] - p >= 3 * SCAN
                           && sq_cyc[0] - p <= 4 * SCAN + 3), 32'd1);
    check_strobes("mid_rst");

    // random held sets of 0..2 keys
    for (int it = 0; it < 14; it++) begin
      s = '0;
      p = int'($urandom_range(0, 2));
      if (p >= 1) s[$urandom_range(0, 15)] = 1'b1;
      if (p == 2) s[$urandom_range(0, 15)] = 1'b1;
      apply(s);
      tick((DB + 2) * SCAN + int'($urandom_range(0, 15)));
      chk("rand_down", 32'(key_down), 32'(s != 16'h0));
      chk("rand_multi", 32'(multi_key), 32'($countones(s) >= 2));
    end
    check_strobes("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
